// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               zero_ext;
  logic [1:0]         ALUOp;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
           ALUOp, pc_source, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
           ALUOp, pc_source, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset datapath: fetch/decode/execute/mem/writeback.
// Moore outputs; memory states hold until mem_ready when MEM_WAIT_EN=1.
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    LOGI_EX  = 4'd10,
    IMM_WB   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   mem_done;

  assign mem_done  = bus.mem_ready || !MEM_WAIT_EN;
  assign bus.state = STATE_W'(state_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = FETCH;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.zero_ext      = 1'b0;
    bus.ALUOp         = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = mem_done;
        bus.pc_write  = mem_done;
        state_d       = mem_done ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          6'b100011, 6'b101011:          state_d = MEMADR;
          6'b000000:                     state_d = RTYPE_EX;
          6'b000100:                     state_d = BEQ_EX;
          6'b001000:                     state_d = ADDI_EX;
          6'b001100, 6'b001101, 6'b001110: state_d = LOGI_EX;
          6'b000010:                     state_d = JUMP;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        // opcode bit 3 separates sw (101011) from lw (100011)
        state_d       = bus.opcode[3] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        state_d      = mem_done ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        state_d       = mem_done ? FETCH : MEMWR;
      end
      RTYPE_EX: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOp     = 2'b10;
        state_d       = RTYPE_WB;
      end
      RTYPE_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      BEQ_EX: begin
        bus.alu_src_a     = 1'b1;
        bus.ALUOp         = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = IMM_WB;
      end
      LOGI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.zero_ext  = 1'b1;
        bus.ALUOp     = 2'b11;
        state_d       = IMM_WB;
      end
      IMM_WB: begin
        bus.reg_write = 1'b1;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: state_d = FETCH;
    endcase

    // Reset overrides everything, including the two non-Moore terms above.
    if (rst) begin
      state_d           = FETCH;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.zero_ext      = 1'b0;
      bus.ALUOp         = 2'b00;
      bus.pc_source     = 2'b00;
      bus.illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction path model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb;
    logic       zx;
    logic [1:0] aluop, psrc;
    logic       ill;
  } ctl_t;

  int path_q[$];

  function automatic ctl_t obs_ctl();
    ctl_t c;
    c.pw = bus.pc_write;    c.pwc = bus.pc_write_cond; c.iord = bus.iord;
    c.mr = bus.mem_read;    c.mw = bus.mem_write;      c.irw = bus.ir_write;
    c.m2r = bus.mem_to_reg; c.rdst = bus.reg_dst;      c.rw = bus.reg_write;
    c.asa = bus.alu_src_a;  c.asb = bus.alu_src_b;     c.zx = bus.zero_ext;
    c.aluop = bus.ALUOp;    c.psrc = bus.pc_source;    c.ill = bus.illegal_op;
    return c;
  endfunction

  // Expected control word for a state, straight from the state descriptions.
  function automatic ctl_t exp_ctl(int s, logic rdy, logic ill);
    ctl_t c = '0;
    case (s)
      0:  begin c.mr = 1; c.asb = 2'b01; c.irw = rdy; c.pw = rdy; end
      1:  begin c.asb = 2'b11; c.ill = ill; end
      2:  begin c.asa = 1; c.asb = 2'b10; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.asa = 1; c.aluop = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.asa = 1; c.aluop = 2'b01; c.pwc = 1; c.psrc = 2'b01; end
      9:  begin c.asa = 1; c.asb = 2'b10; end
      10: begin c.asa = 1; c.asb = 2'b10; c.zx = 1; c.aluop = 2'b11; end
      11: begin c.rw = 1; end
      12: begin c.pw = 1; c.psrc = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic void build_path(logic [5:0] op);
    path_q = {0, 1};
    case (op)
      6'b100011: path_q = {path_q, 2, 3, 4};
      6'b101011: path_q = {path_q, 2, 5};
      6'b000000: path_q = {path_q, 6, 7};
      6'b000100: path_q = {path_q, 8};
      6'b001000: path_q = {path_q, 9, 11};
      6'b001100, 6'b001101, 6'b001110: path_q = {path_q, 10, 11};
      6'b000010: path_q = {path_q, 12};
      default: ;
    endcase
  endfunction

  function automatic int base_cycles(logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return base_cycles(op) != 2;
  endfunction

  // Walks one instruction; each cycle: drive at negedge, check 1 time unit later.
  task automatic run_instr(input logic [5:0] op, input int max_wait);
    int waits_total = 0;
    int cycles = 0;
    build_path(op);
    foreach (path_q[i]) begin
      int s = path_q[i];
      int wait_left = (s == 0 || s == 3 || s == 5) ? $urandom_range(0, max_wait) : 0;
      bit done = 0;
      waits_total += wait_left;
      while (!done) begin
        ctl_t e, o;
        @(negedge clk);
        rst = 1'b0;
        if (s == 0 || s == 3 || s == 5) bus.mem_ready = (wait_left == 0);
        else                            bus.mem_ready = 1'($urandom_range(0, 1));
        bus.opcode = (s == 0) ? 6'($urandom) : op;
        #1;
        e = exp_ctl(s, bus.mem_ready, (s == 1) && !is_legal(op));
        o = obs_ctl();
        total++;
        if (bus.state !== 4'(s)) begin
          bad++;
          $display("FAIL state op=%b: got %0d want %0d", op, bus.state, s);
        end
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL ctl op=%b st=%0d: got %h want %h", op, s, o, e);
        end
        total++;
        if ((o.mw && o.rw) || (o.pw && o.pwc)) begin
          bad++;
          $display("FAIL exclusive enables st=%0d: got %h want no mw&rw/pw&pwc", s, o);
        end
        cycles++;
        if (wait_left == 0) done = 1;
        else wait_left--;
      end
    end
    total++;
    if (cycles != base_cycles(op) + waits_total) begin
      bad++;
      $display("FAIL cycles op=%b: got %0d want %0d", op, cycles, base_cycles(op) + waits_total);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;
    repeat (2) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.state !== 4'd0 || obs_ctl() !== ctl_t'('0)) begin
        bad++;
        $display("FAIL reset hold: got st=%0d ctl=%h want st=0 ctl=0", bus.state, obs_ctl());
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || obs_ctl() !== exp_ctl(0, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL reset release: got st=%0d ctl=%h want st=0 ctl=%h",
               bus.state, obs_ctl(), exp_ctl(0, 1'b1, 1'b0));
    end
    // Re-enter reset for one cycle so the next task starts cleanly in FETCH.
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rtype();        run_instr(6'b000000, 0); endtask
  task automatic test_lw_wait();      run_instr(6'b100011, 2); endtask
  task automatic test_sw();           run_instr(6'b101011, 2); endtask
  task automatic test_imm();          run_instr(6'b001101, 0); run_instr(6'b001000, 1);
                                      run_instr(6'b001100, 0); run_instr(6'b001110, 0); endtask
  task automatic test_branch_jump();  run_instr(6'b000100, 0); run_instr(6'b000010, 1); endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL illegal after: got st=%0d ill=%b want st=0 ill=0", bus.state, bus.illegal_op);
    end
  endtask

  task automatic test_reset_midway();
    run_instr(6'b000000, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1;
      bus.opcode = 6'b101011;
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
      bad++;
      $display("FAIL memwr hold: got st=%0d mw=%b want st=5 mw=1", bus.state, bus.mem_write);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_write !== 1'b0 || obs_ctl() !== ctl_t'('0)) begin
      bad++;
      $display("FAIL reset midway: got mw=%b ctl=%h want 0", bus.mem_write, obs_ctl());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0) begin
      bad++;
      $display("FAIL reset midway next: got st=%0d want 0", bus.state);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                             6'b001100, 6'b001101, 6'b001110, 6'b000010, 6'b000000};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 9)];
      run_instr(op, 3);
    end
  endtask

  initial begin
    bus.opcode = 6'b0;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_imm();
    test_branch_jump();
    test_illegal();
    test_reset_midway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
